multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/mc_pkg.sv | 54 +++++
 rtl/mc_decode.sv | 38 +++
 rtl/multicycle_ctrl.sv | 131 +++++++++++++
 tb/tb_multicycle_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle controller: FSM states, opcode/funct
// constants, datapath select encodings and the decoded instruction class.
package mc_pkg;

  typedef enum logic [2:0] {
    ST_IF   = 3'd0,
    ST_ID   = 3'd1,
    ST_EXE  = 3'd2,
    ST_MEM  = 3'd3,
    ST_WB   = 3'd4,
    ST_HALT = 3'd5
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;

  localparam logic [1:0] EXT_ZERO  = 2'b00;
  localparam logic [1:0] EXT_SIGN  = 2'b01;
  localparam logic [1:0] EXT_UPPER = 2'b10;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_OR    = 3'b010;
  localparam logic [2:0] ALU_PASSB = 3'b011;

  localparam logic [1:0] PC_PLUS4  = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    CL_ADDU,
    CL_SUBU,
    CL_ORI,
    CL_ADDIU,
    CL_LUI,
    CL_LW,
    CL_SW,
    CL_BEQ,
    CL_J,
    CL_HALT,
    CL_ILLEGAL
  } iclass_e;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction classifier: opcode/funct -> class plus illegal flag.
// lui is only recognised when MULTICYCLE_CTRL_LUI_EN is defined.
module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  output iclass_e    iclass_o,
  output logic       illegal_o
);

  always_comb begin
    iclass_o = CL_ILLEGAL;
    case (opcode_i)
      OP_RTYPE: begin
        case (funct_i)
          FN_ADDU: iclass_o = CL_ADDU;
          FN_SUBU: iclass_o = CL_SUBU;
          default: iclass_o = CL_ILLEGAL;
        endcase
      end
      OP_ORI:   iclass_o = CL_ORI;
      OP_ADDIU: iclass_o = CL_ADDIU;
`ifdef MULTICYCLE_CTRL_LUI_EN
      OP_LUI:   iclass_o = CL_LUI;
`endif
      OP_LW:    iclass_o = CL_LW;
      OP_SW:    iclass_o = CL_SW;
      OP_BEQ:   iclass_o = CL_BEQ;
      OP_J:     iclass_o = CL_J;
      OP_HALT:  iclass_o = CL_HALT;
      default:  iclass_o = CL_ILLEGAL;
    endcase
  end

  assign illegal_o = (iclass_o == CL_ILLEGAL);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle datapath controller: IF/ID/EXE/MEM/WB/HALT state machine.
// Optional lui support is enabled by defining MULTICYCLE_CTRL_LUI_EN.
module multicycle_ctrl
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_we,
  output logic       ir_we,
  output logic       reg_we,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       mem_re,
  output logic       mem_we,
  output logic       alu_src_b,
  output logic [1:0] ext_op,
  output logic [2:0] alu_op,
  output logic [1:0] pc_src,
  output logic [2:0] state,
  output logic       halted,
  output logic       illegal
);

  state_e  state_q, state_d;
  iclass_e iclass;
  logic    dec_illegal;

  mc_decode u_decode (
    .opcode_i  (opcode),
    .funct_i   (funct),
    .iclass_o  (iclass),
    .illegal_o (dec_illegal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IF;
    else        state_q <= state_d;
  end

  // Immediate/ALU selects follow the decoded class from ID through WB.
  always_comb begin
    ext_op    = EXT_ZERO;
    alu_op    = ALU_ADD;
    alu_src_b = 1'b0;
    if (state_q inside {ST_ID, ST_EXE, ST_MEM, ST_WB}) begin
      case (iclass)
        CL_ADDU:  alu_op = ALU_ADD;
        CL_SUBU:  alu_op = ALU_SUB;
        CL_ORI:   begin ext_op = EXT_ZERO; alu_op = ALU_OR;  alu_src_b = 1'b1; end
        CL_ADDIU: begin ext_op = EXT_SIGN; alu_op = ALU_ADD; alu_src_b = 1'b1; end
`ifdef MULTICYCLE_CTRL_LUI_EN
        CL_LUI:   begin ext_op = EXT_UPPER; alu_op = ALU_PASSB; alu_src_b = 1'b1; end
`endif
        CL_LW,
        CL_SW:    begin ext_op = EXT_SIGN; alu_op = ALU_ADD; alu_src_b = 1'b1; end
        CL_BEQ:   begin ext_op = EXT_SIGN; alu_op = ALU_SUB; end
        default:  ;
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_we      = 1'b0;
    ir_we      = 1'b0;
    reg_we     = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    mem_re     = 1'b0;
    mem_we     = 1'b0;
    pc_src     = PC_PLUS4;
    illegal    = 1'b0;
    case (state_q)
      ST_IF: begin
        mem_re = 1'b1;
        // Reset parks the FSM in IF; keep the fetch strobes quiet while it is held.
        if (mem_ready && rst_n) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          state_d = ST_ID;
        end
      end
      ST_ID: begin
        if (dec_illegal) begin
          illegal = 1'b1;
          state_d = ST_HALT;
        end else if (iclass == CL_HALT) begin
          state_d = ST_HALT;
        end else if (iclass == CL_J) begin
          pc_we   = 1'b1;
          pc_src  = PC_JUMP;
          state_d = ST_IF;
        end else begin
          state_d = ST_EXE;
        end
      end
      ST_EXE: begin
        if (iclass == CL_BEQ) begin
          pc_we   = zero;
          pc_src  = PC_BRANCH;
          state_d = ST_IF;
        end else if (iclass inside {CL_LW, CL_SW}) begin
          state_d = ST_MEM;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        mem_re = (iclass == CL_LW);
        mem_we = (iclass == CL_SW);
        if (mem_ready) state_d = (iclass == CL_LW) ? ST_WB : ST_IF;
      end
      ST_WB: begin
        reg_we     = 1'b1;
        reg_dst    = (iclass inside {CL_ADDU, CL_SUBU});
        mem_to_reg = (iclass == CL_LW);
        state_d    = ST_IF;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IF;
    endcase
  end

  assign state  = state_q;
  assign halted = (state_q == ST_HALT);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks each instruction class, reset
// during MEM, illegal decode and the absorbing HALT state.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic [5:0] funct = 6'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pc_we, ir_we, reg_we, reg_dst, mem_to_reg, mem_re, mem_we, alu_src_b;
  logic [1:0] ext_op, pc_src;
  logic [2:0] alu_op, state;
  logic       halted, illegal;
  logic [4:0] en;

  int pass_cnt = 0;
  int total_cnt = 0;

  multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_we(pc_we), .ir_we(ir_we), .reg_we(reg_we),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .mem_re(mem_re), .mem_we(mem_we),
    .alu_src_b(alu_src_b), .ext_op(ext_op), .alu_op(alu_op), .pc_src(pc_src),
    .state(state), .halted(halted), .illegal(illegal)
  );

  always #5 clk = ~clk;

  assign en = {pc_we, ir_we, reg_we, mem_re, mem_we};

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Advance one clock; lands 1 time unit after the falling edge.
  task automatic nxt();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    mem_ready = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("rst_state", 8'(state), 8'd0);
    check("rst_mem_re", 8'(mem_re), 8'd1);
    check("rst_en_quiet", 8'({pc_we, ir_we, reg_we, mem_we}), 8'd0);
    check("rst_selects", 8'({ext_op, alu_op, pc_src, halted}), 8'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // addu
    opcode = 6'h00; funct = 6'h21;
    #1;
    check("addu_if_fetch", 8'({state, ir_we, pc_we, mem_re}), 8'b000_1_1_1);
    check("addu_if_pcsrc", 8'(pc_src), 8'd0);
    nxt();
    check("addu_id", 8'({state, illegal}), 8'b001_0);
    check("addu_id_en", 8'(en), 8'd0);
    nxt();
    check("addu_exe", 8'({state, alu_op, alu_src_b, reg_we}), 8'b010_000_0_0);
    nxt();
    check("addu_wb", 8'({state, reg_we, reg_dst, mem_to_reg}), 8'b100_1_1_0);
    nxt();
    check("addu_back_if", 8'(state), 8'd0);

    // lw with three wait cycles in MEM
    opcode = 6'h23;
    nxt();
    check("lw_id_ext", 8'({state, ext_op}), 8'b001_01);
    nxt();
    check("lw_exe", 8'({state, ext_op, alu_op, alu_src_b}), 8'b010_01_000_1);
    mem_ready = 1'b0;
    nxt();
    for (int i = 0; i < 3; i++) begin
      check("lw_mem_wait", 8'({state, mem_re, mem_we, reg_we}), 8'b011_1_0_0);
      nxt();
    end
    mem_ready = 1'b1;
    #1;
    check("lw_mem_ready", 8'({state, mem_re}), 8'b011_1);
    nxt();
    check("lw_wb", 8'({state, reg_we, reg_dst, mem_to_reg}), 8'b100_1_0_1);
    check("lw_wb_ext", 8'(ext_op), 8'd1);
    nxt();
    check("lw_back_if", 8'(state), 8'd0);

    // beq taken, then not taken
    opcode = 6'h04; zero = 1'b1;
    nxt();
    nxt();
    check("beq_t_exe", 8'({state, pc_we, pc_src, alu_op}), 8'b010_1_01_001);
    nxt();
    check("beq_t_if", 8'(state), 8'd0);
    zero = 1'b0;
    nxt();
    nxt();
    check("beq_nt_exe", 8'({state, pc_we}), 8'b010_0);
    nxt();
    check("beq_nt_if", 8'(state), 8'd0);

    // j
    opcode = 6'h02;
    nxt();
    check("j_id", 8'({state, pc_we, pc_src}), 8'b001_1_10);
    nxt();
    check("j_if", 8'(state), 8'd0);

    // subu
    opcode = 6'h00; funct = 6'h23;
    nxt();
    nxt();
    check("subu_exe", 8'({state, alu_op, alu_src_b}), 8'b010_001_0);
    nxt();
    check("subu_wb", 8'({state, reg_we, reg_dst}), 8'b100_1_1);
    nxt();

    // ori
    opcode = 6'h0D;
    nxt();
    check("ori_id_ext", 8'(ext_op), 8'd0);
    nxt();
    check("ori_exe", 8'({state, alu_op, alu_src_b}), 8'b010_010_1);
    nxt();
    check("ori_wb", 8'({state, reg_we, reg_dst, mem_to_reg}), 8'b100_1_0_0);
    nxt();

    // addiu
    opcode = 6'h09;
    nxt();
    nxt();
    check("addiu_exe", 8'({ext_op, alu_op, alu_src_b}), 8'b01_000_1);
    nxt();
    check("addiu_wb", 8'({state, reg_we, reg_dst}), 8'b100_1_0);
    nxt();
    check("addiu_if", 8'(state), 8'd0);

    // sw interrupted by reset in MEM, then fetch resumes and sw completes
    opcode = 6'h2B;
    nxt();
    nxt();
    mem_ready = 1'b0;
    nxt();
    check("sw_mem", 8'({state, mem_we, mem_re}), 8'b011_1_0);
    #2 rst_n = 1'b0;
    #1;
    check("sw_rst_now", 8'({state, mem_we, mem_re}), 8'b000_0_1);
    check("sw_rst_en", 8'({pc_we, ir_we, reg_we}), 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("sw_rel_if", 8'({state, ir_we}), 8'b000_0);
    nxt();
    check("sw_rel_wait", 8'({state, mem_re}), 8'b000_1);
    mem_ready = 1'b1;
    #1;
    check("sw_rel_fetch", 8'({ir_we, pc_we}), 8'b11);
    nxt();
    check("sw_rel_id", 8'(state), 8'd1);
    nxt();
    nxt();
    check("sw_mem_done", 8'({state, mem_we}), 8'b011_1);
    nxt();
    check("sw_to_if", 8'({state, reg_we}), 8'b000_0);

    // lui
    opcode = 6'h0F;
    nxt();
`ifdef MULTICYCLE_CTRL_LUI_EN
    check("lui_id", 8'({state, ext_op, illegal}), 8'b001_10_0);
    nxt();
    check("lui_exe", 8'({state, ext_op, alu_op, alu_src_b}), 8'b010_10_011_1);
    nxt();
    check("lui_wb", 8'({state, reg_we, reg_dst}), 8'b100_1_0);
    nxt();
    check("lui_if", 8'(state), 8'd0);
`else
    check("lui_illegal", 8'({state, illegal, ext_op}), 8'b001_1_00);
    nxt();
    check("lui_halt", 8'({state, illegal, halted}), 8'b101_0_1);
    do_reset();
    check("lui_reset", 8'(state), 8'd0);
`endif

    // unknown funct under R-type
    opcode = 6'h00; funct = 6'h00;
    nxt();
    check("badfn_illegal", 8'({state, illegal}), 8'b001_1);
    nxt();
    check("badfn_halt", 8'({state, illegal}), 8'b101_0);
    do_reset();

    // halt: absorbing for 20 cycles
    opcode = 6'h3F;
    nxt();
    check("halt_id", 8'({state, illegal}), 8'b001_0);
    nxt();
    for (int i = 0; i < 20; i++) begin
      check("halt_hold", 8'({state, halted, en}), 8'({3'b101, 1'b1, 5'b00000}));
      zero = ~zero;
      opcode = 6'(i);
      nxt();
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
